// File: rtl/fpnew_opgroup_ordered_merge.sv
// Purpose : issue/retire stage for an FP operation group. Steers each accepted op to one
//           slice, remembers the slice index in an order FIFO and merges slice results into
//           one stream (issue order when InOrder=1, lowest-index-first when InOrder=0).
// Latency : 0 cycles on both issue and retire paths (pure combinational steering/muxing).
// Backpressure: issue stalls when Depth ops are outstanding or the target slice is not ready.
//           Retire stalls on out_ready_i. In order mode, results from non-head slices are
//           held off via ch_out_ready_o.
// Ports   : clk_i/rst_ni (async active-low), flush_i clears all tracking state;
//           issue_* is the op input, ch_in_* goes to the slices, ch_out_*/ch_result_i/
//           ch_status_i/ch_ext_bit_i/ch_tag_i come back from the slices, result_o/status_o/
//           extension_bit_o/tag_o/out_valid_o/out_ready_i form the merged output stream,
//           outstanding_o/busy_o report in-flight ops.
module fpnew_opgroup_ordered_merge #(
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8,
  parameter int unsigned Width       = 32,
  parameter bit          InOrder     = 1'b1,
  parameter type         TagType     = logic,
  localparam int unsigned CW = $clog2(NumChannels),
  localparam int unsigned OW = $clog2(Depth + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 issue_valid_i,
  input  logic [CW-1:0]                        issue_ch_i,
  output logic                                 issue_ready_o,
  output logic [NumChannels-1:0]               ch_in_valid_o,
  input  logic [NumChannels-1:0]               ch_in_ready_i,
  input  logic [NumChannels-1:0]               ch_out_valid_i,
  output logic [NumChannels-1:0]               ch_out_ready_o,
  input  logic [NumChannels-1:0][Width-1:0]    ch_result_i,
  input  logic [NumChannels-1:0][4:0]          ch_status_i,
  input  logic [NumChannels-1:0]               ch_ext_bit_i,
  input  TagType [NumChannels-1:0]             ch_tag_i,
  output logic [Width-1:0]                     result_o,
  output logic [4:0]                           status_o,
  output logic                                 extension_bit_o,
  output TagType                               tag_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [OW-1:0]                        outstanding_o,
  output logic                                 busy_o
);

  localparam int unsigned PW = $clog2(Depth);

  logic [CW-1:0] order_q [Depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] count_q;

  logic          run;        // handshakes only while out of reset and not flushing
  logic          empty, full;
  logic          ch_ok, issue_ok, sel_in_rdy;
  logic          push, pop;
  logic [CW-1:0] head, sel;
  logic          sel_vld;

  assign run   = rst_ni & ~flush_i;
  assign empty = (count_q == '0);
  assign full  = (count_q == OW'(Depth));

  // ---------------- issue side ----------------
  assign ch_ok    = (32'(issue_ch_i) < NumChannels);
  // full uses the registered count: a same-cycle retire does not free a slot
  assign issue_ok = issue_valid_i & run & ~full & ch_ok;

  always_comb begin
    ch_in_valid_o = '0;
    sel_in_rdy    = 1'b0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (issue_ch_i == CW'(c)) begin
        ch_in_valid_o[c] = issue_ok;
        sel_in_rdy       = ch_in_ready_i[c];
      end
    end
  end

  assign issue_ready_o = issue_ok & sel_in_rdy;
  assign push          = issue_ready_o;

  // ---------------- retire side ----------------
  assign head = order_q[rd_ptr_q];

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (InOrder) begin
      sel = head;
      for (int c = 0; c < int'(NumChannels); c++) begin
        if (head == CW'(c)) sel_vld = ch_out_valid_i[c];
      end
    end else begin
      // descending scan so the lowest valid index wins
      for (int c = int'(NumChannels) - 1; c >= 0; c--) begin
        if (ch_out_valid_i[c]) begin
          sel     = CW'(c);
          sel_vld = 1'b1;
        end
      end
    end
  end

  // empty also gates priority mode: no result may retire without a tracked op
  assign out_valid_o = run & ~empty & sel_vld;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    ch_out_ready_o  = '0;
    result_o        = '0;
    status_o        = '0;
    extension_bit_o = 1'b0;
    tag_o           = '0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (sel == CW'(c)) begin
        // in order mode the head slice is offered ready even before its result is valid
        ch_out_ready_o[c] = run & ~empty & out_ready_i & (InOrder ? 1'b1 : sel_vld);
        if (out_valid_o) begin
          result_o        = ch_result_i[c];
          status_o        = ch_status_i[c];
          extension_bit_o = ch_ext_bit_i[c];
          tag_o           = ch_tag_i[c];
        end
      end
    end
  end

  // ---------------- order FIFO ----------------
  always_ff @(posedge clk_i) begin
    if (push) order_q[wr_ptr_q] <= issue_ch_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + OW'(1);
      else if (pop && !push) count_q <= count_q - OW'(1);
    end
  end

  assign outstanding_o = count_q;
  assign busy_o        = (count_q != '0);

  // ---------------- invariants ----------------
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
  if (InOrder) begin : g_onehot
    a_rdy_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ch_out_ready_o));
  end

endmodule
